dram_arbiter: RTL
=================

Name: dram_arbiter

Overview:
- Round-robin Avalon-MM arbiter that shares the single-port 512x32 on-chip data RAM (controller_dram) between NUM_MASTERS requesters.
- Grants at most one read or write per cycle and forwards it combinationally to the RAM.
- Returns read data one cycle later, tagged to the issuing master with readdatavalid.
- Sits between the processor/DMA masters and the RAM slave port.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..4).
- ADDR_W, 9, word address width; RAM depth = 2**ADDR_W.
- DATA_W, 32, data width; byteenable width = DATA_W/8.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m_address  in  NUM_MASTERS*ADDR_W  per-master word address, master i at slice i
- m_read  in  NUM_MASTERS  per-master read request
- m_write  in  NUM_MASTERS  per-master write request
- m_byteenable  in  NUM_MASTERS*DATA_W/8  per-master byte enables
- m_writedata  in  NUM_MASTERS*DATA_W  per-master write data
- m_waitrequest  out  NUM_MASTERS  high = command not accepted this cycle
- m_readdata  out  DATA_W  read data, shared by all masters
- m_readdatavalid  out  NUM_MASTERS  one-hot, qualifies m_readdata
- hold_req  in  1  freeze RAM access; drives RAM reset_req
- ram_address  out  ADDR_W  to RAM address
- ram_byteenable  out  DATA_W/8  to RAM byteenable
- ram_writedata  out  DATA_W  to RAM writedata
- ram_chipselect  out  1  to RAM chipselect
- ram_write  out  1  to RAM write
- ram_clken  out  1  to RAM clken
- ram_readdata  in  DATA_W  from RAM q (valid the cycle after the address edge)
- err_rw  out  1  sticky: a master asserted read and write together

Behaviour:
- Request vector: req[i] = m_read[i] | m_write[i]. All grant logic is combinational from req, the pointer and hold_req.
- Grant: if hold_req = 0 and any req, grant exactly one master, the first requesting index at or after rr_ptr, wrapping modulo NUM_MASTERS.
- m_waitrequest[i] = ~grant[i]. It is 1 for idle masters and during hold_req.
- Pointer: at the clk edge with a grant to master g, rr_ptr <= (g+1) mod NUM_MASTERS. With no grant, rr_ptr holds. Reset value 0.
- RAM drive:
  - ram_address, ram_byteenable and ram_writedata are muxed from the granted master.
  - With no grant they drive 0.
  - ram_chipselect = any grant.
  - ram_write = granted master's m_write.
  - ram_clken = ~hold_req.
- Read latency is exactly 1 cycle.
  - A granted read in cycle N sets rd_pend <= 1 and rd_tag <= g.
  - In cycle N+1: m_readdatavalid[rd_tag] = rd_pend and m_readdata = ram_readdata.
  - rd_pend clears the following cycle unless a new read is granted.
  - Back-to-back reads from any mix of masters sustain one per cycle.
  - m_readdata is 0 whenever rd_pend = 0.
- Writes complete in the grant cycle and produce no readdatavalid.
- Read and write asserted together by one master:
  - treated as a write; the read is dropped;
  - err_rw <= 1, stays set until reset.
- Read-after-write, same address, consecutive cycles: the read returns the new data. RAM ordering guarantees this; no forwarding is required.
- hold_req:
  - While 1: no new grants, ram_clken = 0.
  - A read granted in the cycle before hold_req rises still completes. rd_pend is captured before the hold and its RAM output is stable because the clock enable is off.
  - While hold_req = 1: rd_pend clears after it is delivered, and rr_ptr holds.
- Reset (asynchronous, reset_n = 0):
  - rr_ptr = 0, rd_pend = 0, rd_tag = 0, err_rw = 0.
  - m_readdatavalid = 0, m_readdata = 0.
  - m_waitrequest = all 1, ram_chipselect = 0, ram_write = 0.
  - A read in flight when reset asserts is discarded and never returns valid.
- Release is synchronous to clk: the first grant can occur in the first cycle after reset_n rises.

Decomposition:
- Package dram_arb_pkg: default ADDR_W/DATA_W constants, the master-index width function clog2(NUM_MASTERS), and the read-tag typedef.
- One sub-module, rr_grant: a pure combinational round-robin picker taking req and ptr and producing a one-hot grant plus a binary index. It is reused by the bus-fabric arbiters.
- Pointer and read-tag registers live in the top.

Test Plan:
- Reset: hold reset_n = 0 with m_read = 2'b11 -> m_waitrequest = 2'b11, ram_chipselect = 0, m_readdatavalid = 0; after release the first grant goes to master 0.
- Contention: both masters read continuously, addresses 0x010/0x020 -> grants alternate m0,m1,m0,m1. Each readdatavalid comes one cycle after its grant with the matching tag and preloaded data, one valid per cycle.
- Write/read: m1 writes 0xDEADBEEF to 0x1FF with byteenable 4'b0011, then reads 0x1FF next cycle -> low halfword 0xBEEF is merged into the prior contents; data returns on cycle +1 to m1 only.
- Hold: m0 read granted, hold_req rises the next cycle for 3 cycles -> m0 readdatavalid is still delivered. No grants and ram_clken = 0 for 3 cycles; rr_ptr unchanged; m1 is granted first after release if it was next.
- Illegal command: m0 asserts read and write to 0x005 with 0x12345678 -> the write is performed, no readdatavalid, err_rw = 1 and sticky until reset_n pulses.
- Async reset mid-read: assert reset_n low between the grant and the return -> no readdatavalid appears and err_rw/rr_ptr return to 0 immediately.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_arb_pkg
// Description : Shared constants, index-width helper and read-tag type for
//               the data-RAM arbiter and the bus-fabric round-robin pickers.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_arb_pkg;

    // Default geometry of the on-chip data RAM (512 x 32)
    localparam int C_DEF_ADDR_W = 9;
    localparam int C_DEF_DATA_W = 32;

    // Largest supported requester count and the tag width that covers it
    localparam int C_MAX_MASTERS = 4;
    localparam int C_TAG_W       = 2;

    // Read tag: identifies which master a returning read belongs to
    typedef logic [C_TAG_W-1:0] rd_tag_t;

    // Width of a binary master index; never less than one bit
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : dram_arb_pkg
`default_nettype wire

// File: rtl/dram_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant
// Description : Pure combinational round-robin picker. Grants the first
//               requester at or after i_ptr, wrapping modulo N_REQ. Produces
//               a one-hot grant, its binary index and an any-grant flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Requester count expressed at the width of the wrap arithmetic
    localparam logic [IDX_W:0] C_N = (IDX_W+1)'(N_REQ);

    logic [IDX_W:0] w_cand;

    // Scan requesters starting at the pointer; first hit wins
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // ptr < N_REQ and k < N_REQ, so one subtraction wraps the sum
            w_cand = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_cand >= C_N) begin
                w_cand = w_cand - C_N;
            end
            if (!o_any && i_req[w_cand[IDX_W-1:0]]) begin
                o_any                     = 1'b1;
                o_gnt[w_cand[IDX_W-1:0]]  = 1'b1;
                o_idx                     = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule : rr_grant
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_arbiter
// Description : Round-robin Avalon-MM arbiter sharing the single-port data
//               RAM between NUM_MASTERS requesters. One command per cycle is
//               forwarded combinationally to the RAM; read data returns one
//               cycle later tagged with a one-hot readdatavalid.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = C_DEF_ADDR_W,
    parameter int DATA_W      = C_DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    // Master side
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_address,
    input  logic [NUM_MASTERS-1:0]            m_read,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS*DATA_W/8-1:0]   m_byteenable,
    input  logic [NUM_MASTERS*DATA_W-1:0]     m_writedata,
    output logic [NUM_MASTERS-1:0]            m_waitrequest,
    output logic [DATA_W-1:0]                 m_readdata,
    output logic [NUM_MASTERS-1:0]            m_readdatavalid,
    // Freeze control
    input  logic                          hold_req,
    // RAM side
    output logic [ADDR_W-1:0]             ram_address,
    output logic [DATA_W/8-1:0]           ram_byteenable,
    output logic [DATA_W-1:0]             ram_writedata,
    output logic                          ram_chipselect,
    output logic                          ram_write,
    output logic                          ram_clken,
    input  logic [DATA_W-1:0]             ram_readdata,
    // Status
    output logic                          err_rw
);

    localparam int C_BE_W  = DATA_W / 8;
    localparam int C_IDX_W = idx_width(NUM_MASTERS);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(NUM_MASTERS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [C_IDX_W-1:0] r_rr_ptr;
    logic               r_rd_pend;
    rd_tag_t            r_rd_tag;
    logic               r_err_rw;

    // ------------------------------------------------------------------------
    // Grant path
    // ------------------------------------------------------------------------
    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_req_eff;
    logic [NUM_MASTERS-1:0] w_gnt;
    logic [C_IDX_W-1:0]     w_gnt_idx;
    logic                   w_gnt_any;
    logic                   w_gnt_write;
    logic                   w_gnt_read;
    logic [C_IDX_W-1:0]     w_ptr_nxt;
    logic                   w_rw_conflict;

    // Requests are masked while frozen or while reset is applied, so no
    // command reaches the RAM and every master sees waitrequest
    always_comb begin
        w_req     = m_read | m_write;
        w_req_eff = (hold_req || !reset_n) ? '0 : w_req;
    end

    rr_grant #(
        .N_REQ (NUM_MASTERS),
        .IDX_W (C_IDX_W)
    ) u_rr_grant (
        .i_req (w_req_eff),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_gnt_any)
    );

    // Classify the granted command; a read+write combination is a write
    always_comb begin
        w_gnt_write   = |(w_gnt & m_write);
        w_gnt_read    = |(w_gnt & m_read & ~m_write);
        w_ptr_nxt     = (w_gnt_idx == C_LAST_IDX) ? '0 : (w_gnt_idx + 1'b1);
        w_rw_conflict = |(m_read & m_write);
    end

    // ------------------------------------------------------------------------
    // RAM command mux: one-hot grant selects the master's slice, else zero
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_addr;
    logic [C_BE_W-1:0] w_be;
    logic [DATA_W-1:0] w_wdata;

    // Select address/byteenable/writedata of the granted master
    always_comb begin
        w_addr  = '0;
        w_be    = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_gnt[i]) begin
                w_addr  = m_address[i*ADDR_W +: ADDR_W];
                w_be    = m_byteenable[i*C_BE_W +: C_BE_W];
                w_wdata = m_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------

    // Advance the pointer past the winner; hold when nothing is granted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_any) begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    // Track the single outstanding read; it lives exactly one cycle and a
    // reset discards it before it can be reported
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend <= 1'b0;
            r_rd_tag  <= '0;
        end else begin
            r_rd_pend <= w_gnt_read;
            if (w_gnt_read) begin
                r_rd_tag <= rd_tag_t'(w_gnt_idx);
            end
        end
    end

    // Sticky flag for any master driving read and write together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_rw <= 1'b0;
        end else if (w_rw_conflict) begin
            r_err_rw <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------

    // Drive RAM port and master handshake from the current grant
    always_comb begin
        m_waitrequest  = ~w_gnt;
        ram_address    = w_addr;
        ram_byteenable = w_be;
        ram_writedata  = w_wdata;
        ram_chipselect = w_gnt_any;
        ram_write      = w_gnt_write;
        ram_clken      = ~hold_req;
        err_rw         = r_err_rw;
        // RAM q is only meaningful in the cycle after a granted read
        m_readdata     = r_rd_pend ? ram_readdata : '0;
    end

    // Decode the pending tag into the one-hot valid vector
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rdv
        assign m_readdatavalid[gi] = r_rd_pend && (r_rd_tag == rd_tag_t'(gi));
    end

endmodule : dram_arbiter
`default_nettype wire
